mul_seq: RTL
============

Name: mul_seq

Overview:
- Iterative shift-add multiply sequencer for the multi-cycle ARM core.
- Takes over the multiply that the decoder flags with opMul (Op=00, Funct[5:4]=00, Instr[7:4]=1001). The main FSM holds its execute state while busy=1.
- Produces the low WIDTH bits of Rn*Rm plus N/Z flags for the MULS flag update.
- Sits beside the ALU in the datapath. The main FSM launches it with start and consumes result on done.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNTW, 6, width of the iteration counter; must satisfy 2^CNTW > WIDTH.

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low; clears all state when sampled 0 on a clk edge.
- start  input  1  launch request; sampled only in IDLE.
- a  input  WIDTH  multiplicand (Rn), captured on accepted start.
- b  input  WIDTH  multiplier (Rm), captured on accepted start.
- busy  output  1  high in RUN and DONE; main FSM stalls on it.
- done  output  1  one-cycle pulse; result and flags valid this cycle.
- result  output  WIDTH  low WIDTH bits of a*b; holds until next accepted start.
- flag_n  output  1  result[WIDTH-1], registered with result.
- flag_z  output  1  1 when result==0, registered with result.

Behaviour:
- Reset: clk and reset are the single clock and its synchronous active-low reset, named as elsewhere in the core.
  - reset=0 at an edge forces state=IDLE and clears acc, mcand, mplier, count and result to 0.
  - After reset: busy=0, done=0, result=0, flag_n=0, flag_z=0.
  - Reset mid-RUN or in DONE aborts the operation. No done pulse is produced for the aborted operation.
- States: IDLE, RUN, DONE (2-bit encoding, free choice).
- IDLE: busy=0, done=0.
  - start=1 at an edge: acc<=0, mcand<=a, mplier<=b, count<=0, then go to RUN.
  - start=0: stay in IDLE.
- RUN: busy=1. Each cycle:
  - If mplier[0]=1, acc <= acc+mcand, truncated mod 2^WIDTH (carries beyond WIDTH are discarded).
  - mcand <= mcand<<1; mplier <= mplier>>1 (logical shift); count <= count+1.
  - When count==WIDTH-1, the update is the final one: latch result and flags from the final acc, then go to DONE.
- DONE: busy=1, done=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency: start accepted at edge k. RUN occupies cycles k+1..k+WIDTH. done is high in cycle k+WIDTH+1. With WIDTH=32, that is 33 cycles from start to done.
- Boundary conditions:
  - start while busy=1 (RUN or DONE) is ignored; a and b are not re-sampled.
  - start held high continuously: a new operation is accepted in the first IDLE cycle after DONE. No back-to-back acceptance from DONE.
  - a and b may change after acceptance without affecting the operation.
  - result, flag_n and flag_z change only at the DONE-entry edge or on reset; they are stable in IDLE.
  - Signedness is irrelevant: the low-word product is identical for signed and unsigned operands.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined:
  - At the start of each RUN cycle, if mplier==0, skip the update, latch result and flags from the current acc, and go to DONE.
  - Latency becomes (index of highest set bit of b)+2 RUN cycles, capped at WIDTH.
  - b=0 gives 1 RUN cycle; done is in cycle k+2.
  - b=1 gives 2 RUN cycles; done is in cycle k+3.
- Undefined: always exactly WIDTH RUN cycles, as specified above.
- Result values are identical in both builds; only timing differs.

Test Plan:
- Reset held 0 for 2 cycles, then released -> busy=0, done=0, result=0, flag_z=0, flag_n=0.
- a=7, b=6, start pulse at edge k -> busy high from k+1; done only in cycle k+33; result=0x0000002A, flag_n=0, flag_z=0.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0x00000001. Then a=0x80000000, b=1 -> result=0x80000000, flag_n=1.
- a=0x12345678, b=0 -> result=0, flag_z=1. With MUL_EARLY_EXIT_EN defined, done is in cycle k+2; without it, done is in cycle k+33.
- start re-asserted at k+5 with a=3, b=3 during an op with a=5, b=5 -> ignored; result=0x19; the next op starts only after returning to IDLE.
- reset=0 at k+10 of an op with a=9, b=9 -> next cycle state=IDLE, busy=0, result=0; no done pulse ever appears for that op.

Source files
------------

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b plus N/Z flags.
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module mul_seq #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNTW-1:0]  count;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        acc_next = acc;
        if (mplier[0]) acc_next = acc + mcand;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            result <= '0;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc    <= '0;
                        mcand  <= a;
                        mplier <= b;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
`ifdef MUL_EARLY_EXIT_EN
                    if (mplier == '0) begin
                        result <= acc;
                        flag_n <= acc[WIDTH-1];
                        flag_z <= (acc == '0);
                        done   <= 1'b1;
                        state  <= DONE;
                    end else
`endif
                    begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + 1'b1;
                        // Final step: flags come from the updated accumulator, not the stale one.
                        if (count == LAST) begin
                            result <= acc_next;
                            flag_n <= acc_next[WIDTH-1];
                            flag_z <= (acc_next == '0);
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
